// File: rtl/breath_ramp_sequencer.sv
// Breath envelope sequencer: steps a rise/hold-high/fall/hold-low duty ramp once per PWM period.
// Latency: update 1 clk after period_end; 2 clk with BREATH_RAMP_SEQUENCER_GAMMA_EN (square-law duty).
// Backpressure: none; the PWM generator loads duty on every update strobe.
module breath_ramp_sequencer #(
    parameter int WIDTH   = 17,
    parameter int PEAK    = 46875,
    parameter int STEP    = 183,
    parameter int HOLD_HI = 0,
    parameter int HOLD_LO = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             period_end,
    output logic [WIDTH-1:0] duty,
    output logic             update,
    output logic [2:0]       phase,
    output logic             cycle_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    if (STEP < 1 || PEAK < 1 || $clog2(PEAK + 1) > WIDTH) begin : g_param_check
        $error("breath_ramp_sequencer: PEAK must fit in WIDTH bits and STEP must be nonzero");
    end

    // A step larger than PEAK behaves exactly like a step of PEAK, and keeps sums in WIDTH+1 bits.
    localparam int STEP_EFF = (STEP > PEAK) ? PEAK : STEP;
    localparam int HOLD_MAX = (HOLD_HI > HOLD_LO) ? HOLD_HI : HOLD_LO;
    localparam int CW       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [WIDTH-1:0] PEAK_W   = WIDTH'(PEAK);
    localparam logic [WIDTH:0]   PEAK_X   = (WIDTH + 1)'(PEAK);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP_EFF);
    localparam logic [CW-1:0]    HOLD_HI_C = CW'(HOLD_HI);
    localparam logic [CW-1:0]    HOLD_LO_C = CW'(HOLD_LO);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ramp_q, ramp_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic             upd_q, upd_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   rise_sum;
    logic [WIDTH-1:0] rise_val;
    logic [WIDTH-1:0] fall_val;
    logic             go_rise, go_fall;

    assign rise_sum = {1'b0, ramp_q} + {1'b0, STEP_W};
    assign rise_val = (rise_sum >= PEAK_X) ? PEAK_W : rise_sum[WIDTH-1:0];
    assign fall_val = (ramp_q >= STEP_W) ? (ramp_q - STEP_W) : '0;

    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        hold_d  = hold_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        go_rise = 1'b0;
        go_fall = 1'b0;
        if (period_end) begin
            if (!enable) begin
                if (state_q != S_IDLE) begin
                    state_d = S_IDLE;
                    ramp_d  = '0;
                    hold_d  = '0;
                    upd_d   = 1'b1;
                end
            end else begin
                upd_d = 1'b1;
                case (state_q)
                    S_IDLE, S_RISE: go_rise = 1'b1;
                    S_HOLD_HI: begin
                        if (hold_q == HOLD_HI_C) go_fall = 1'b1;
                        else                     hold_d  = hold_q + 1'b1;
                    end
                    S_FALL: go_fall = 1'b1;
                    S_HOLD_LO: begin
                        if (hold_q == HOLD_LO_C) go_rise = 1'b1;
                        else                     hold_d  = hold_q + 1'b1;
                    end
                    default: begin
                        state_d = S_IDLE;
                        ramp_d  = '0;
                        hold_d  = '0;
                    end
                endcase
                // Leaving a hold counts as the first step of the next slope.
                if (go_rise) begin
                    ramp_d  = rise_val;
                    hold_d  = '0;
                    state_d = S_RISE;
                    if (rise_val == PEAK_W) state_d = (HOLD_HI > 0) ? S_HOLD_HI : S_FALL;
                end
                if (go_fall) begin
                    ramp_d  = fall_val;
                    hold_d  = '0;
                    state_d = S_FALL;
                    if (fall_val == '0) begin
                        done_d  = 1'b1;
                        state_d = (HOLD_LO > 0) ? S_HOLD_LO : S_RISE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ramp_q  <= '0;
            hold_q  <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_d;
            hold_q  <= hold_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
        end
    end

    assign phase = state_q;

`ifdef BREATH_RAMP_SEQUENCER_GAMMA_EN
    localparam int            PW     = 2 * WIDTH + 33;
    localparam logic [32:0]   GSCALE = 33'((64'd1 << 32) / PEAK);

    logic [PW-1:0]    gamma_prod;
    logic [WIDTH-1:0] duty_g;
    logic             upd_g, done_g;

    assign gamma_prod = PW'(ramp_q) * PW'(ramp_q) * PW'(GSCALE);

    // Extra stage keeps update and cycle_done aligned with the corrected duty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_g <= '0;
            upd_g  <= 1'b0;
            done_g <= 1'b0;
        end else begin
            duty_g <= WIDTH'(gamma_prod >> 32);
            upd_g  <= upd_q;
            done_g <= done_q;
        end
    end

    assign duty       = duty_g;
    assign update     = upd_g;
    assign cycle_done = done_g;
`else
    assign duty       = ramp_q;
    assign update     = upd_q;
    assign cycle_done = done_q;
`endif

endmodule

// File: tb/tb_breath_ramp_sequencer.sv
// Bench for breath_ramp_sequencer: two instances (held ramp, one-step saturation) checked by scoreboard.
module tb_breath_ramp_sequencer;

    localparam int W = 17;

    typedef struct {
        int duty;
        int phase;
        bit done;
        int cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         period_end = 1'b0;
    logic [W-1:0] duty_a, duty_b;
    logic         upd_a, upd_b, done_a, done_b;
    logic [2:0]   phase_a, phase_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    breath_ramp_sequencer #(.WIDTH(W), .PEAK(10), .STEP(4), .HOLD_HI(1), .HOLD_LO(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .period_end(period_end),
        .duty(duty_a), .update(upd_a), .phase(phase_a), .cycle_done(done_a)
    );

    breath_ramp_sequencer #(.WIDTH(W), .PEAK(10), .STEP(12), .HOLD_HI(0), .HOLD_LO(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .period_end(period_end),
        .duty(duty_b), .update(upd_b), .phase(phase_b), .cycle_done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (reset_n) begin
            if (upd_a) begin
                if (qa.size() == 0) chk("a_unexpected_update", upd_a, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_duty", duty_a, e.duty);
                    chk("a_phase", phase_a, e.phase);
                    chk("a_done", done_a, e.done);
                    chk("a_latency", cyc, e.cyc);
                end
            end else begin
                if (done_a) chk("a_stray_done", done_a, 0);
                if (qa.size() > 0 && qa[0].cyc <= cyc) begin
                    chk("a_missing_update", upd_a, 1);
                    void'(qa.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (reset_n) begin
            if (upd_b) begin
                if (qb.size() == 0) chk("b_unexpected_update", upd_b, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_duty", duty_b, e.duty);
                    chk("b_phase", phase_b, e.phase);
                    chk("b_done", done_b, e.done);
                    chk("b_latency", cyc, e.cyc);
                end
            end else begin
                if (done_b) chk("b_stray_done", done_b, 0);
                if (qb.size() > 0 && qb[0].cyc <= cyc) begin
                    chk("b_missing_update", upd_b, 1);
                    void'(qb.pop_front());
                end
            end
        end
    end

    // One period_end pulse followed by idle cycles, 8 clk per period.
    task automatic pulse(input bit en,
                         input bit pa, input int da, input int pha, input bit dna,
                         input bit pb, input int db, input int phb, input bit dnb);
        @(negedge clk);
        enable     = en;
        period_end = 1'b1;
        if (pa) qa.push_back('{da, pha, dna, cyc + 1});
        if (pb) qb.push_back('{db, phb, dnb, cyc + 1});
        @(negedge clk);
        period_end = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int a_duty[14] = '{4, 8, 10, 10, 6, 2, 0, 0, 4, 8, 10, 10, 6, 0};
        int a_ph[14]   = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1, 2, 2, 3, 0};

        repeat (3) @(negedge clk);
        chk("rst_duty_a", duty_a, 0);
        chk("rst_upd_a", upd_a, 0);
        chk("rst_phase_a", phase_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_phase_b", phase_b, 0);
        reset_n = 1'b1;

        // Enabled but no period_end: nothing may move.
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (20) @(negedge clk);
            chk("quiet_duty", duty_a, 0);
            chk("quiet_phase", phase_a, 0);
        end

        // Full breath; the last entry drops enable in the same cycle as period_end.
        for (int i = 0; i < 14; i++) begin
            if (i == 13) pulse(1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
            else if (i % 2 == 0)
                pulse(1'b1, 1'b1, a_duty[i], a_ph[i], i == 6, 1'b1, 10, 3, 1'b0);
            else
                pulse(1'b1, 1'b1, a_duty[i], a_ph[i], i == 6, 1'b1, 0, 1, 1'b1);
        end

        // Disabled and idle: period_end produces no update.
        pulse(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        pulse(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("dis_duty_a", duty_a, 0);
        chk("dis_phase_a", phase_a, 0);

        // Re-enable restarts from RISE.
        pulse(1'b1, 1'b1, 4, 1, 1'b0, 1'b1, 10, 3, 1'b0);
        pulse(1'b1, 1'b1, 8, 1, 1'b0, 1'b1, 0, 1, 1'b1);

        // Asynchronous reset mid-RISE, away from any clock edge.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_duty_a", duty_a, 0);
        chk("arst_upd_a", upd_a, 0);
        chk("arst_phase_a", phase_a, 0);
        chk("arst_phase_b", phase_b, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("arst_hold_duty_a", duty_a, 0);
        chk("arst_hold_phase_a", phase_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_phase_a", phase_a, 0);
        chk("post_rst_phase_b", phase_b, 0);
        pulse(1'b1, 1'b1, 4, 1, 1'b0, 1'b1, 10, 3, 1'b0);

        repeat (4) @(negedge clk);
        chk("a_pending", qa.size(), 0);
        chk("b_pending", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
